// File: rtl/burst_flow.sv
// burst_flow: burst-mode memory sequencer. Runs BurstLen+1 consecutive read or
// write accesses from a latched start address, with transmit/receive handshakes.
`default_nettype none

module burst_flow #(
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Active,
  input  logic          Mode,
  input  logic          ValidCmd,
  input  logic          RW,
  input  logic [AW-1:0] StartAddr,
  input  logic [LW-1:0] BurstLen,
  input  logic          DataValid,
  input  logic          TxDone,
  output logic          AccessMem,
  output logic          RWMem,
  output logic [AW-1:0] MemAddr,
  output logic          SampleData,
  output logic          TxData,
  output logic          Busy,
  output logic          BurstDone,
  output logic          Aborted
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    TX      = 3'd2,
    WR_WAIT = 3'd3,
    WR_SMP  = 3'd4,
    WR_ACC  = 3'd5,
    DONE    = 3'd6,
    ABORT   = 3'd7
  } state_t;

  state_t        state, nxt_state;
  logic [AW-1:0] addr, nxt_addr;
  logic [LW-1:0] cnt, nxt_cnt;

  assign MemAddr = addr;

  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (Active && Mode && ValidCmd) begin
          nxt_addr  = StartAddr;
          nxt_cnt   = BurstLen;
          nxt_state = RW ? WR_WAIT : RD_ACC;
        end
      end
      DONE, ABORT: nxt_state = IDLE;
      default: begin
        // Dropping Active outranks every handshake in the burst states
        if (!Active) begin
          nxt_state = ABORT;
        end else begin
          case (state)
            RD_ACC: nxt_state = TX;
            TX: begin
              if (TxDone) begin
                if (cnt == '0) begin
                  nxt_state = DONE;
                end else begin
                  nxt_addr  = addr + AW'(1);
                  nxt_cnt   = cnt - LW'(1);
                  nxt_state = RD_ACC;
                end
              end
            end
            WR_WAIT: if (DataValid) nxt_state = WR_SMP;
            WR_SMP:  nxt_state = WR_ACC;
            WR_ACC: begin
              if (cnt == '0) begin
                nxt_state = DONE;
              end else begin
                nxt_addr  = addr + AW'(1);
                nxt_cnt   = cnt - LW'(1);
                nxt_state = WR_WAIT;
              end
            end
            default: nxt_state = IDLE;
          endcase
        end
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      AccessMem  <= 1'b0;
      RWMem      <= 1'b0;
      SampleData <= 1'b0;
      TxData     <= 1'b0;
      Busy       <= 1'b0;
      BurstDone  <= 1'b0;
      Aborted    <= 1'b0;
    end else begin
      state      <= nxt_state;
      addr       <= nxt_addr;
      cnt        <= nxt_cnt;
      AccessMem  <= (nxt_state == RD_ACC) || (nxt_state == WR_ACC);
      RWMem      <= (nxt_state == WR_ACC);
      SampleData <= (nxt_state == WR_SMP);
      TxData     <= (nxt_state == TX);
      Busy       <= (nxt_state != IDLE);
      BurstDone  <= (nxt_state == DONE);
      Aborted    <= (nxt_state == ABORT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_burst_flow.sv
// tb_burst_flow: directed self-checking bench for burst_flow.
`default_nettype none

module tb_burst_flow;

  logic       Clk = 1'b1;
  logic       Reset;
  logic       Active, Mode, ValidCmd, RW, DataValid, TxDone;
  logic [7:0] StartAddr;
  logic [3:0] BurstLen;
  logic       AccessMem, RWMem, SampleData, TxData, Busy, BurstDone, Aborted;
  logic [7:0] MemAddr;

  int tests = 0;
  int fails = 0;
  int busy_cycles;
  logic [7:0] exp_addr;

  burst_flow #(.AW(8), .LW(4)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode), .ValidCmd(ValidCmd),
    .RW(RW), .StartAddr(StartAddr), .BurstLen(BurstLen), .DataValid(DataValid),
    .TxDone(TxDone), .AccessMem(AccessMem), .RWMem(RWMem), .MemAddr(MemAddr),
    .SampleData(SampleData), .TxData(TxData), .Busy(Busy), .BurstDone(BurstDone),
    .Aborted(Aborted)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {AccessMem, RWMem, SampleData, TxData, Busy, BurstDone, Aborted};
  endfunction

  initial begin
    Reset = 1'b1; Active = 1'b0; Mode = 1'b0; ValidCmd = 1'b0; RW = 1'b0;
    DataValid = 1'b0; TxDone = 1'b0; StartAddr = 8'h00; BurstLen = 4'h0;
    #2;
    chk("reset_flags", 32'(flags()), 32'h0);
    chk("reset_addr", 32'(MemAddr), 32'h00);
    #3 Reset = 1'b0;
    step();
    chk("idle_flags", 32'(flags()), 32'h0);

    // Read burst 0x10, 3 words; TxDone one cycle after TxData rises
    Active = 1'b1; Mode = 1'b1; ValidCmd = 1'b1; RW = 1'b0;
    StartAddr = 8'h10; BurstLen = 4'd2;
    step();
    ValidCmd = 1'b0;
    for (int w = 0; w < 3; w++) begin
      exp_addr = 8'h10 + 8'(w);
      chk("rd_access", 32'({AccessMem, RWMem, Busy, TxData}), 32'b1010);
      chk("rd_addr", 32'(MemAddr), 32'(exp_addr));
      if (w == 1) begin
        ValidCmd = 1'b1; RW = 1'b1; StartAddr = 8'h80;
      end
      step();
      ValidCmd = 1'b0; RW = 1'b0;
      chk("rd_tx1", 32'({AccessMem, TxData, Busy}), 32'b011);
      step();
      chk("rd_tx2", 32'({TxData, MemAddr}), 32'({1'b1, exp_addr}));
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
    end
    chk("rd_done", 32'(flags()), 32'b0000110);
    step();
    chk("rd_idle", 32'(flags()), 32'h0);
    chk("rd_hold_addr", 32'(MemAddr), 32'h12);

    // Write burst 0xFE, 4 words, DataValid tied high, address wraps
    DataValid = 1'b1; ValidCmd = 1'b1; RW = 1'b1; StartAddr = 8'hFE; BurstLen = 4'd3;
    step();
    ValidCmd = 1'b0; RW = 1'b0;
    busy_cycles = 0;
    for (int w = 0; w < 4; w++) begin
      exp_addr = 8'hFE + 8'(w);
      chk("wr_wait", 32'(flags()), 32'b0000100);
      if (Busy) busy_cycles++;
      step();
      chk("wr_smp", 32'({flags(), MemAddr}), 32'({7'b0010100, exp_addr}));
      if (Busy) busy_cycles++;
      step();
      chk("wr_acc", 32'({flags(), MemAddr}), 32'({7'b1100100, exp_addr}));
      if (Busy) busy_cycles++;
      step();
    end
    chk("wr_done", 32'(flags()), 32'b0000110);
    if (Busy) busy_cycles++;
    step();
    chk("wr_idle", 32'(flags()), 32'h0);
    chk("wr_busy_len", 32'(busy_cycles), 32'd13);
    DataValid = 1'b0;

    // Commands that must be ignored
    Mode = 1'b0; ValidCmd = 1'b1; StartAddr = 8'h33;
    step();
    chk("mode0_ignored", 32'({flags(), MemAddr}), 32'({7'b0, 8'h01}));
    Mode = 1'b1; Active = 1'b0;
    step();
    chk("inactive_ignored", 32'({flags(), MemAddr}), 32'({7'b0, 8'h01}));
    ValidCmd = 1'b0; Active = 1'b1;

    // Abort in TX with TxDone raised the same cycle
    ValidCmd = 1'b1; RW = 1'b0; StartAddr = 8'h20; BurstLen = 4'd1;
    step();
    ValidCmd = 1'b0;
    chk("ab_rdacc", 32'(flags()), 32'b1000100);
    step();
    chk("ab_tx", 32'(flags()), 32'b0001100);
    Active = 1'b0; TxDone = 1'b1;
    step();
    chk("ab_abort", 32'(flags()), 32'b0000101);
    Active = 1'b1; TxDone = 1'b0;
    step();
    chk("ab_idle", 32'(flags()), 32'h0);
    step();
    chk("ab_idle2", 32'(flags()), 32'h0);

    // Reset asserted while waiting for write data
    ValidCmd = 1'b1; RW = 1'b1; StartAddr = 8'h40; BurstLen = 4'd2;
    step();
    ValidCmd = 1'b0; RW = 1'b0;
    step();
    chk("rst_wrwait", 32'({flags(), MemAddr}), 32'({7'b0000100, 8'h40}));
    Reset = 1'b1;
    #1;
    chk("rst_async", 32'({flags(), MemAddr}), 32'h0);
    #1 Reset = 1'b0;
    step();
    chk("rst_after", 32'({flags(), MemAddr}), 32'h0);

    // Fresh single-word read at 0x05 with TxDone tied high
    TxDone = 1'b1; ValidCmd = 1'b1; StartAddr = 8'h05; BurstLen = 4'd0;
    step();
    ValidCmd = 1'b0;
    chk("rd5_acc", 32'({flags(), MemAddr}), 32'({7'b1000100, 8'h05}));
    step();
    chk("rd5_tx", 32'(flags()), 32'b0001100);
    step();
    chk("rd5_done", 32'(flags()), 32'b0000110);
    step();
    chk("rd5_idle", 32'({flags(), MemAddr}), 32'({7'b0, 8'h05}));
    TxDone = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/burst_flow.md
# burst_flow

Mode-1 (burst) companion to the Mode-0 single-access read/write controller. It accepts one command and sequences a run of consecutive memory accesses from a start address. Read bursts hand each word to the transmitter with a TxData/TxDone handshake. Write bursts sample each incoming word on DataValid and then commit it to memory. It drives the same memory/transmit strobes as the Mode-0 controller; the two are mutually exclusive by Mode.

## Interface
Parameters:
- AW, 8, memory address width
- LW, 4, burst-length field width; a burst is BurstLen+1 words (1..2^LW)

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- Active  in  1  block enable; low aborts any burst in progress
- Mode  in  1  1 = burst mode; commands with Mode=0 are ignored
- ValidCmd  in  1  command strobe, sampled in IDLE only
- RW  in  1  command direction: 0 = read, 1 = write
- StartAddr  in  AW  first word address, latched with the command
- BurstLen  in  LW  word count minus one, latched with the command
- DataValid  in  1  write word available from the receiver
- TxDone  in  1  transmitter finished the current word
- AccessMem  out  1  memory access strobe, one cycle per word
- RWMem  out  1  direction for the memory access (1 = write); valid when AccessMem=1, otherwise 0
- MemAddr  out  AW  current word address
- SampleData  out  1  one-cycle pulse: capture incoming write word
- TxData  out  1  level: word ready for transmission
- Busy  out  1  high from the cycle after acceptance until return to IDLE
- BurstDone  out  1  one-cycle pulse on normal completion
- Aborted  out  1  one-cycle pulse when Active drop kills a burst

## Operation
- States: IDLE, RD_ACC, TX, WR_WAIT, WR_SMP, WR_ACC, DONE, ABORT.
- IDLE: if Active & Mode & ValidCmd are all high, latch addr=StartAddr and cnt=BurstLen. Go to RD_ACC (RW=0) or WR_WAIT (RW=1). Otherwise stay in IDLE.
- RD_ACC: AccessMem=1, RWMem=0 for one cycle, then TX.
- TX: TxData=1 held until TxDone is sampled high.
  - If cnt==0, go to DONE.
  - Otherwise addr+=1, cnt-=1, go to RD_ACC.
- WR_WAIT: Busy only; wait for DataValid high, then go to WR_SMP.
- WR_SMP: SampleData=1 for one cycle, then WR_ACC.
- WR_ACC: AccessMem=1, RWMem=1 for one cycle.
  - If cnt==0, go to DONE.
  - Otherwise addr+=1, cnt-=1, go to WR_WAIT.
- DONE: BurstDone=1 and Busy=1 for one cycle, then IDLE.
- Active sampled low in any state other than IDLE/DONE/ABORT: go to ABORT. ABORT outputs Aborted=1 and Busy=1 for one cycle, then IDLE. The abort check takes priority over every other transition, including TxDone and DataValid.
- Address arithmetic is modulo 2^AW: 0xFF+1 wraps to 0x00.
- MemAddr holds the last address while in IDLE.
- ValidCmd, StartAddr, BurstLen and RW are ignored outside IDLE.
- TxDone outside TX and DataValid outside WR_WAIT are ignored.

## Timing
- All outputs are registered (Moore, decoded from registered state); there is no combinational input-to-output path.
- Reset: state=IDLE, addr=0, cnt=0. All outputs are 0, including MemAddr=0.
- Command sampled at edge k: Busy and the first state are visible after edge k.
- Read: AccessMem is high during the cycle after acceptance.
- Read word minimum is 2 cycles (RD_ACC + TX with TxDone already high). A read burst of N words with TxDone tied high takes 2N+1 cycles, including DONE.
- Write word minimum is 3 cycles (WR_WAIT + WR_SMP + WR_ACC) with DataValid tied high. A write burst of N words takes 3N+1 cycles.
- MemAddr updates on the edge leaving TX or WR_ACC. It is stable throughout the AccessMem cycle.
- ValidCmd asserted in the DONE cycle is ignored; a new command is accepted no earlier than the first IDLE cycle.
- Reset asserted mid-burst returns the block to IDLE asynchronously and clears all outputs immediately. No BurstDone or Aborted pulse is generated.

## Test plan
- Reset=1 for 5 ns, then 0 -> all outputs 0, MemAddr=0x00, Busy=0.
- Read, StartAddr=0x10, BurstLen=2, TxDone high 1 cycle after each TxData rise:
  - 3 AccessMem pulses with RWMem=0 at MemAddr 0x10, 0x11, 0x12.
  - 3 TxData periods.
  - BurstDone pulses once, then Busy=0.
- Write, StartAddr=0xFE, BurstLen=3, DataValid tied high:
  - SampleData/AccessMem pairs with RWMem=1 at 0xFE, 0xFF, 0x00, 0x01 (wrap).
  - Total Busy duration is 13 cycles.
- Mode=0 or Active=0 with ValidCmd=1 -> no state change, Busy stays 0.
- Also: ValidCmd pulsed mid-burst -> ignored, and the burst completes unchanged.
- Read burst with Active dropped while in TX and TxDone raised the same cycle:
  - ABORT wins; Aborted pulses once and BurstDone does not.
  - Block is in IDLE 2 cycles later.
- Reset asserted mid-write in WR_WAIT:
  - Outputs clear immediately.
  - After release, a new read command at 0x05 behaves normally.
